// File: rtl/twelve_disp_pkg.sv
// Package: twelve_disp_pkg
//   Shared constants for the twelve_disp_scan display stage: 7-segment codes
//   (bit order {g,f,e,d,c,b,a}, active-high), the all-digits-off anode
//   pattern, and a counter-width helper used for the prescaler and flash timer.
package twelve_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] AN_NONE   = 2'b11;

  // Bits needed for a counter that must hold values 0..n-1 (never below 1).
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Module: seg7_decode
//   Combinational digit-to-segment decoder. Dash has priority over blank,
//   blank has priority over the digit value.
// Ports:
//   digit  in  4  decimal digit 0..9 (10..15 render as dash)
//   blank  in  1  1 = all segments off
//   dash   in  1  1 = middle segment only
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
  import twelve_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a value on every path through this block, so no latch is inferred.
    seg = SEG_DASH;
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/twelve_disp_scan.sv
// Module: twelve_disp_scan
//   Samples a mod-12 counter value and shows it as two decimal digits on a
//   multiplexed 7-segment display. Values above MAX_VAL show "--".
//   Optional feature macro: CO_FLASH_EN -- when defined, a CO_IN pulse lights
//   DP for FLASH_CYC cycles; when undefined DP is tied low and CO_IN is ignored.
// Ports:
//   CLK    in   1  clock, rising edge
//   MR     in   1  asynchronous reset, active-high
//   EN     in   1  1 = capture Q_IN every cycle, 0 = hold displayed value
//   Q_IN   in   4  counter value
//   CO_IN  in   1  counter carry-out pulse
//   SEG    out  7  segments {g,f,e,d,c,b,a}, active-high
//   AN     out  2  digit enables, active-low; AN[0]=ones, AN[1]=tens
//   DP     out  1  decimal point, active-high
module twelve_disp_scan
  import twelve_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int MAX_VAL   = 11,
  parameter int BLANK_LZ  = 1,
  parameter int FLASH_CYC = 16
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       EN,
  input  logic [3:0] Q_IN,
  input  logic       CO_IN,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       DP
);

  localparam int              DIV_W    = cnt_width(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      MAX_Q    = 4'(MAX_VAL);

  logic [3:0]       val_r;
  logic [DIV_W-1:0] div_cnt;
  logic             sel;       // 0 = ones slot, 1 = tens slot

  logic             dash;
  logic             tens;
  logic [3:0]       ones;
  logic [3:0]       digit;
  logic             blank;
  logic [6:0]       seg_next;

  // Capture register and scan prescaler.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      val_r   <= 4'd0;
      div_cnt <= '0;
      sel     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (EN) val_r <= Q_IN;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sel     <= ~sel;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Split the held value into decimal digits and pick the one for this slot.
  always_comb begin
    dash  = (val_r > MAX_Q);
    tens  = 1'b0;
    ones  = val_r;
    if (!dash && (val_r >= 4'd10)) begin
      tens = 1'b1;
      ones = val_r - 4'd10;
    end
    digit = sel ? {3'b000, tens} : ones;
    // Dash overrides blanking inside the decoder, so out-of-range shows "--".
    blank = sel && (BLANK_LZ != 0) && !tens;
  end

  seg7_decode u_decode (
    .digit (digit),
    .blank (blank),
    .dash  (dash),
    .seg   (seg_next)
  );

  // Registered outputs: one cycle behind sel, AN and SEG update together.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      SEG <= SEG_BLANK;
      AN  <= AN_NONE;
    end else begin
      SEG <= seg_next;
      AN  <= ~(2'b01 << sel);
    end
  end

`ifdef CO_FLASH_EN
  localparam int FL_W = cnt_width(FLASH_CYC + 1);

  logic [FL_W-1:0] flash_cnt;

  // A CO_IN pulse (re)loads the full count; DP is lit while the count is nonzero.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      flash_cnt <= '0;
      DP        <= 1'b0;
    end else begin
      if (CO_IN) begin
        flash_cnt <= FL_W'(FLASH_CYC);
      end else if (flash_cnt != '0) begin
        flash_cnt <= flash_cnt - FL_W'(1);
      end
      DP <= (flash_cnt != '0);
    end
  end
`else
  localparam int unused_flash_cyc = FLASH_CYC;
  logic unused_co_in;

  assign unused_co_in = CO_IN;
  assign DP           = 1'b0;
`endif

endmodule

// File: tb/tb_twelve_disp_scan.sv
// Testbench: tb_twelve_disp_scan
//   Directed and randomized stimulus for twelve_disp_scan (SCAN_DIV=4,
//   FLASH_CYC=16). Expected outputs come from a value-level reference model:
//   slot from the edge count since reset, digits from divide/modulo, DP from
//   the distance to the most recent carry pulse.
module tb_twelve_disp_scan;

  localparam int SCAN_DIV  = 4;
  localparam int MAX_VAL   = 11;
  localparam int FLASH_CYC = 16;

  logic       CLK;
  logic       MR;
  logic       EN;
  logic [3:0] Q_IN;
  logic       CO_IN;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       DP;

  int tests;
  int fails;

  // Reference model state.
  int m_val;       // value currently held for display
  int m_edge;      // edges since reset release
  int m_last_co;   // edge index of most recent carry pulse, -1 if none

  logic [6:0] seg_tbl [10];

  twelve_disp_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .MAX_VAL   (MAX_VAL),
    .BLANK_LZ  (1),
    .FLASH_CYC (FLASH_CYC)
  ) dut (
    .CLK   (CLK),
    .MR    (MR),
    .EN    (EN),
    .Q_IN  (Q_IN),
    .CO_IN (CO_IN),
    .SEG   (SEG),
    .AN    (AN),
    .DP    (DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int v, input int slot);
    int t, o;
    if (v > MAX_VAL) return 7'h40;
    t = v / 10;
    o = v % 10;
    if (slot == 0) return seg_tbl[o];
    if (t == 0) return 7'h00;
    return seg_tbl[t];
  endfunction

  task automatic model_reset();
    m_val     = 0;
    m_edge    = 0;
    m_last_co = -1;
  endtask

  // One clock with MR low: predict this edge's outputs, advance the model, compare.
  task automatic tick(input string tag);
    logic       en_s, co_s;
    logic [3:0] q_s;
    int         slot;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_dp;
    en_s = EN;
    q_s  = Q_IN;
    co_s = CO_IN;
    @(posedge CLK);
    slot    = (m_edge / SCAN_DIV) % 2;
    exp_seg = model_seg(m_val, slot);
    exp_an  = (slot == 0) ? 2'b10 : 2'b01;
`ifdef CO_FLASH_EN
    exp_dp  = (m_last_co >= 0) && (m_edge > m_last_co) && (m_edge - m_last_co <= FLASH_CYC);
`else
    exp_dp  = 1'b0;
`endif
    if (en_s) m_val = int'(q_s);
    if (co_s) m_last_co = m_edge;
    m_edge++;
    #1;
    check({tag, "_seg"}, {1'b0, SEG}, {1'b0, exp_seg});
    check({tag, "_an"},  {6'd0, AN},  {6'd0, exp_an});
    check({tag, "_dp"},  {7'd0, DP},  {7'd0, exp_dp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, {1'b0, SEG}, 8'h00);
    check({tag, "_an"},  {6'd0, AN},  8'h03);
    check({tag, "_dp"},  {7'd0, DP},  8'h00);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    MR    = 1'b1;
    EN    = 1'b0;
    Q_IN  = 4'd0;
    CO_IN = 1'b0;
    model_reset();

    // Reset held for three cycles.
    #1;
    check_reset_outputs("rst_t0");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_reset_outputs("rst_hold");
    end
    MR = 1'b0;

    // First edge after release shows the ones digit (value 0).
    tick("first_edge");

    EN = 1'b1; Q_IN = 4'd7;  run("q7", 16);
    Q_IN = 4'd11;            run("q11", 16);
    Q_IN = 4'd10;            run("q10", 16);
    Q_IN = 4'd13;            run("q13", 16);
    EN = 1'b0; Q_IN = 4'd3;  run("hold", 16);
    EN = 1'b1;               run("q3", 16);

    // Carry flash: single pulse, then retrigger 10 cycles later.
    CO_IN = 1'b1; tick("co1");
    CO_IN = 1'b0; run("co1_run", 9);
    CO_IN = 1'b1; tick("co2");
    CO_IN = 1'b0; run("co2_run", 24);

    // Move into a tens slot, then reset between edges.
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      if (AN == 2'b01) break;
      tick("seek_tens");
    end
    check("tens_slot_reached", {6'd0, AN}, 8'h01);
    #2;
    MR = 1'b1;
    #1;
    check_reset_outputs("mr_async");
    @(posedge CLK);
    #1;
    check_reset_outputs("mr_hold");
    MR = 1'b0;
    model_reset();
    Q_IN = 4'd5;
    run("post_mr", 12);

    // Randomized phase.
    for (int i = 0; i < 300; i++) begin
      EN    = ($urandom_range(0, 3) != 0);
      Q_IN  = 4'($urandom_range(0, 15));
      CO_IN = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    CO_IN = 1'b0;
    run("tail", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
